// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - handshake and data bundle between the decode stage, the ALU and the memory stage
interface alu_exec_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opalu;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  br_type;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        br_taken;
   logic        ovf;
   logic [15:0] op_count;

   modport master (
      output in_valid, opalu, a, b, br_type, flush, out_ready,
      input  in_ready, out_valid, result, zero, br_taken, ovf, op_count
   );

   modport slave (
      input  in_valid, opalu, a, b, br_type, flush, out_ready,
      output in_ready, out_valid, result, zero, br_taken, ovf, op_count
   );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage ALU with a one-entry elastic output register
// Optional signed-overflow detection is enabled with `ALU_OVERFLOW_EN; when undefined, ovf is tied to 0.
module alu_exec_stage (
   input  logic            clk,
   input  logic            rst,
   alu_exec_stage_if.slave bus
);
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;

   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_BGTZ = 2'b11;

   logic        out_valid_q;
   logic [31:0] result_q;
   logic        zero_q;
   logic        br_q;
   logic [15:0] cnt_q;

   logic        accept;
   logic        is_nop;
   logic        br_cond;
   logic        nxt_br;
   logic [31:0] nxt_result;
   logic [31:0] sum;
   logic [31:0] diff;

   assign sum  = bus.a + bus.b;
   assign diff = bus.a - bus.b;

   assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // Unknown op codes fall into the NOP path: zero result, no branch, not counted.
   always_comb begin
      is_nop     = 1'b0;
      nxt_result = '0;
      case (bus.opalu)
         OP_AND:  nxt_result = bus.a & bus.b;
         OP_OR:   nxt_result = bus.a | bus.b;
         OP_ADD:  nxt_result = sum;
         OP_SUB:  nxt_result = diff;
         OP_SLT:  nxt_result = {31'b0, ($signed(bus.a) < $signed(bus.b))};
         default: is_nop     = 1'b1;
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (bus.br_type)
         BR_BEQ:  br_cond = (bus.a == bus.b);
         BR_BNE:  br_cond = (bus.a != bus.b);
         BR_BGTZ: br_cond = !bus.a[31] && (bus.a != 32'd0);
         default: br_cond = 1'b0;
      endcase
   end

   assign nxt_br = br_cond && !is_nop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         br_q        <= 1'b0;
         cnt_q       <= '0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= nxt_result;
            zero_q      <= (nxt_result == 32'd0);
            br_q        <= nxt_br;
            if (!is_nop)
               cnt_q <= cnt_q + 16'd1;
         end else if (bus.flush || (out_valid_q && bus.out_ready)) begin
            // Data registers keep their last values; only the valid bit drops.
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef ALU_OVERFLOW_EN
   logic ovf_q;
   logic nxt_ovf;

   always_comb begin
      nxt_ovf = 1'b0;
      if (bus.opalu == OP_ADD)
         nxt_ovf = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
      else if (bus.opalu == OP_SUB)
         nxt_ovf = (bus.a[31] != bus.b[31]) && (diff[31] != bus.a[31]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (accept)
         ovf_q <= nxt_ovf;
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.br_taken  = br_q;
   assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage with directed vectors
module tb_alu_exec_stage;
   logic clk;
   logic rst;

   alu_exec_stage_if bus ();

   alu_exec_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef ALU_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] result;
      logic        zero;
      logic        br;
      logic        ovf;
      logic [15:0] cnt;
   } exp_t;

   exp_t        q[$];
   int          vectors;
   int          miscompares;
   logic [15:0] model_cnt;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; a handshake seen here completes on the next edge.
   task automatic send(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [1:0] bt, input logic counted,
                       input logic [31:0] er, input logic ez, input logic eb, input logic eo);
      exp_t e;
      bit   ok;
      ok = 0;
      bus.in_valid = 1'b1;
      bus.opalu    = op;
      bus.a        = va;
      bus.b        = vb;
      bus.br_type  = bt;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) begin
            ok = 1;
            if (counted) model_cnt = model_cnt + 16'd1;
            e.result = er; e.zero = ez; e.br = eb; e.ovf = eo; e.cnt = model_cnt;
            q.push_back(e);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: got in_ready=0 expected acceptance within 50 cycles");
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_output: got result %0h expected no output", bus.result);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("result",   bus.result,   e.result);
               chk("zero",     bus.zero,     e.zero);
               chk("br_taken", bus.br_taken, e.br);
               chk("ovf",      bus.ovf,      e.ovf);
               chk("op_count", bus.op_count, e.cnt);
            end
         end
      end
   end

   initial begin
      clk = 0;
      rst = 1;
      vectors = 0;
      miscompares = 0;
      model_cnt = 0;
      bus.in_valid = 0;
      bus.opalu = 4'b1111;
      bus.a = 0;
      bus.b = 0;
      bus.br_type = 0;
      bus.flush = 0;
      bus.out_ready = 1;

      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result",    bus.result,    0);
      chk("rst_zero",      bus.zero,      0);
      chk("rst_br",        bus.br_taken,  0);
      chk("rst_ovf",       bus.ovf,       0);
      chk("rst_op_count",  bus.op_count,  0);
      #10;
      rst = 0;
      @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 1);

      //    op       a             b             br     cnt  result        z  br ovf
      send(4'b0010, 32'd5,        32'd7,        2'b00, 1, 32'd12,       0, 0, 0);
      send(4'b0110, 32'd9,        32'd9,        2'b01, 1, 32'd0,        1, 1, 0);
      send(4'b0110, 32'd9,        32'd9,        2'b10, 1, 32'd0,        1, 0, 0);
      send(4'b0111, 32'hFFFFFFFF, 32'd1,        2'b00, 1, 32'd1,        0, 0, 0);
      send(4'b0010, 32'h80000000, 32'd0,        2'b11, 1, 32'h80000000, 0, 0, 0);
      send(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b00, 1, 32'h00F000F0, 0, 0, 0);
      send(4'b0001, 32'h12340000, 32'h00005678, 2'b00, 1, 32'h12345678, 0, 0, 0);
      send(4'b0010, 32'h7FFFFFFF, 32'd1,        2'b00, 1, 32'h80000000, 0, 0, OVF_EN);
      send(4'b1010, 32'd3,        32'd3,        2'b01, 0, 32'd0,        1, 0, 0);
      send(4'b1111, 32'd4,        32'd8,        2'b00, 0, 32'd0,        1, 0, 0);
      send(4'b0000, 32'd5,        32'd0,        2'b11, 1, 32'd0,        1, 1, 0);
      send(4'b0110, 32'h80000000, 32'd1,        2'b00, 1, 32'h7FFFFFFF, 0, 0, OVF_EN);
      send(4'b0111, 32'd3,        32'hFFFFFFFE, 2'b10, 1, 32'd0,        1, 1, 0);
      @(posedge clk); #1;

      // Backpressure: first op held while the second waits.
      bus.out_ready = 0;
      send(4'b0010, 32'd1, 32'd2, 2'b00, 1, 32'd3, 0, 0, 0);
      bus.in_valid = 1;
      bus.opalu = 4'b0001;
      bus.a = 32'd0;
      bus.b = 32'h10;
      bus.br_type = 2'b00;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_result_hold", bus.result, 32'd3);
         @(posedge clk); #1;
      end
      bus.out_ready = 1;
      #0;
      chk("bp_release_in_ready", bus.in_ready, 1);
      begin
         exp_t e;
         model_cnt = model_cnt + 16'd1;
         e.result = 32'h10; e.zero = 0; e.br = 0; e.ovf = 0; e.cnt = model_cnt;
         q.push_back(e);
      end
      @(posedge clk); #1;
      bus.in_valid = 0;
      chk("bp_swap_out_valid", bus.out_valid, 1);
      chk("bp_swap_result", bus.result, 32'h10);
      @(posedge clk); #1;

      // Flush discards the held op and the incoming one.
      bus.out_ready = 0;
      send(4'b0010, 32'd2, 32'd2, 2'b00, 1, 32'd4, 0, 0, 0);
      bus.in_valid = 1;
      bus.opalu = 4'b0010;
      bus.a = 32'd100;
      bus.b = 32'd1;
      bus.flush = 1;
      #0;
      chk("flush_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.flush = 0;
      bus.in_valid = 0;
      void'(q.pop_back());
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_op_count", bus.op_count, model_cnt);
      bus.out_ready = 1;
      @(posedge clk); #1;
      chk("flush_no_output", bus.out_valid, 0);

      send(4'b0010, 32'hFFFFFFFF, 32'd1, 2'b01, 1, 32'd0, 1, 0, 0);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
